// File: rtl/tick_pwm.sv
// tick_pwm: tick-advanced PWM with a shadowed duty applied at period wrap; optional period_start via TICK_PWM_PERIOD_PULSE_EN.
module tick_pwm #(
  parameter int PERIOD = 10,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out
`ifdef TICK_PWM_PERIOD_PULSE_EN
  ,
  output logic             period_start
`endif
);
  localparam logic [WIDTH:0] period_w = (WIDTH+1)'(PERIOD);
  localparam logic [WIDTH-1:0] last = WIDTH'(PERIOD - 1);
  logic [WIDTH-1:0] phase, duty_active, duty_shadow, duty_sat, next_active;
  logic pending, wrap, transfer, next_pwm;
  assign duty_ready = !pending;
  always_comb begin
    wrap = tick && (phase == last);
    transfer = duty_valid && !pending;
    duty_sat = ({1'b0, duty} > period_w) ? period_w[WIDTH-1:0] : duty;
    next_active = (wrap && pending) ? duty_shadow : duty_active;
    next_pwm = wrap ? (next_active != '0) : (({1'b0, phase} + (WIDTH+1)'(1)) < {1'b0, duty_active});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      duty_active <= '0;
      duty_shadow <= '0;
      pending <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      if (tick) begin
        phase <= wrap ? '0 : phase + WIDTH'(1);
        pwm_out <= next_pwm;
      end
      duty_active <= next_active;
      if (transfer) begin
        duty_shadow <= duty_sat;
        pending <= 1'b1;
      end else if (wrap && pending) begin
        pending <= 1'b0;
      end
    end
  end
`ifdef TICK_PWM_PERIOD_PULSE_EN
  always_ff @(posedge clk) period_start <= rst ? 1'b0 : wrap;
`endif
endmodule

// File: tb/tb_tick_pwm.sv
// tb_tick_pwm: table-driven check of tick_pwm with PERIOD=4, plus bounded-wait sequences.
module tb_tick_pwm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [7:0] duty = '0;
  logic duty_valid = 1'b0;
  logic duty_ready, pwm_out;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
`ifdef TICK_PWM_PERIOD_PULSE_EN
  logic period_start;
  tick_pwm #(.PERIOD(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .tick(tick), .duty(duty),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_out(pwm_out), .period_start(period_start));
`else
  tick_pwm #(.PERIOD(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .tick(tick), .duty(duty),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_out(pwm_out));
`endif
  typedef struct {
    logic r, t, v;
    logic [7:0] d;
    logic pwm, rdy, ps;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic r, t, v, input logic [7:0] d, input logic pwm, rdy, ps);
    vec_t x;
    x.r = r; x.t = t; x.v = v; x.d = d; x.pwm = pwm; x.rdy = rdy; x.ps = ps;
    vecs.push_back(x);
  endtask
  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, t, v, input logic [7:0] d);
    rst = r; tick = t; duty_valid = v; duty = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset held 3 cycles with tick/valid toggling
    add(1,1,1,3, 0,1,0); add(1,0,0,0, 0,1,0); add(1,1,1,2, 0,1,0);
    // duty=2 transfer, ignored second offer while pending, applied at wrap
    add(0,1,1,2, 0,0,0); add(0,1,1,4, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 1,1,1);
    add(0,1,0,0, 1,1,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 1,1,1);
    // sparse ticks every 3 cycles: 6 high, 6 low
    add(0,0,0,0, 1,1,0); add(0,0,0,0, 1,1,0); add(0,1,0,0, 1,1,0);
    add(0,0,0,0, 1,1,0); add(0,0,0,0, 1,1,0); add(0,1,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0); add(0,0,0,0, 0,1,0); add(0,1,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0); add(0,0,0,0, 0,1,0); add(0,1,0,0, 1,1,1);
    // duty=0, then 200 saturated to 4, then exactly 4
    add(0,1,1,0, 1,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,1);
    add(0,1,1,200, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 1,1,1);
    add(0,1,0,0, 1,1,0); add(0,1,0,0, 1,1,0); add(0,1,0,0, 1,1,0); add(0,1,0,0, 1,1,1);
    add(0,1,1,4, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,1,1);
    // duty=1, then duty=3 offered on the wrap edge
    add(0,1,1,1, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,1,1);
    add(0,1,0,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,1,3, 1,0,1);
    add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,0,0); add(0,1,0,0, 1,1,1);
    add(0,1,0,0, 1,1,0); add(0,1,0,0, 1,1,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 1,1,1);
    // reset at phase 2 with a pending duty
    add(0,1,0,0, 1,1,0); add(0,1,0,0, 1,1,0); add(0,0,1,4, 1,0,0); add(1,1,1,4, 0,1,0);
    add(0,1,0,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 0,1,1);
    add(0,1,0,0, 0,1,0);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].t, vecs[i].v, vecs[i].d);
      check($sformatf("v%0d pwm_out", i), pwm_out, vecs[i].pwm);
      check($sformatf("v%0d duty_ready", i), duty_ready, vecs[i].rdy);
`ifdef TICK_PWM_PERIOD_PULSE_EN
      check($sformatf("v%0d period_start", i), period_start, vecs[i].ps);
`endif
    end
    // idle with no ticks: output must hold
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      check("hold_no_tick", pwm_out, 1'b0);
    end
    // transfer duty=2 and wait (bounded) for the first high output
    begin
      int n = 0;
      drive(0, 1, 1, 2);
      check("ready_after_xfer", duty_ready, 1'b0);
      while (pwm_out !== 1'b1 && n < 12) begin
        drive(0, 1, 0, 0);
        n++;
      end
      check("pwm_rise_timeout", n < 12, 1'b1);
      check("pwm_rise_latency", n == 2, 1'b1);
      check("ready_after_apply", duty_ready, 1'b1);
      drive(0, 1, 0, 0); check("seq_p1", pwm_out, 1'b1);
      drive(0, 1, 0, 0); check("seq_p2", pwm_out, 1'b0);
      drive(0, 1, 0, 0); check("seq_p3", pwm_out, 1'b0);
      drive(0, 1, 0, 0); check("seq_wrap", pwm_out, 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tick_pwm.md
# tick_pwm

Tick-driven PWM stage that sits directly downstream of `signal_generator`. It consumes that block's single-cycle `out` pulse as its `tick` input and advances a phase counter once per tick. It drives a registered, glitch-free PWM waveform whose duty cycle is reprogrammed through a valid/ready handshake. A new duty value takes effect only at a period boundary.

## Interface
- `PERIOD`, default 10: ticks per PWM period; legal range 2 .. 2**WIDTH-1.
- `WIDTH`, default 8: width of the duty input and the phase counter.
- `clk` input 1: the single clock; all state is clocked on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle advance strobe, normally `signal_generator.out`.
- `duty` input WIDTH: requested high-ticks per period.
- `duty_valid` input 1: `duty` is presented.
- `duty_ready` output 1: the shadow register is free, so a new duty can be accepted.
- `pwm_out` output 1: registered PWM waveform.
- `period_start` output 1: present only with `TICK_PWM_PERIOD_PULSE_EN`; see Configuration.

## Operation
- Internal state:
  - `phase` counts 0 .. PERIOD-1.
  - `duty_active` is the duty in use for the current period.
  - `duty_shadow` holds the next duty.
  - `pending` is set while `duty_shadow` holds an unapplied value.
- `duty_ready` = !pending, driven combinationally from the register.
- Handshake: a transfer occurs on an edge with `duty_valid && duty_ready`.
  - The edge loads `duty_shadow` and sets `pending`.
  - `duty` is saturated to PERIOD before storing; any value > PERIOD is stored as PERIOD.
- Edge with `tick`=1 and `phase` != PERIOD-1:
  - `phase` <= phase+1.
  - `pwm_out` <= (phase+1 < duty_active).
- Edge with `tick`=1 and `phase` == PERIOD-1 (wrap):
  - `phase` <= 0.
  - If `pending`: `duty_active` <= `duty_shadow` and `pending` is cleared.
  - `pwm_out` <= (0 < new duty_active).
- Edge with `tick`=0: `phase`, `duty_active` and `pwm_out` hold.
- Simultaneous events:
  - If a transfer and a wrap occur on the same edge with `pending`=0, the transfer value goes to the shadow register. It is applied at the following wrap, not the current one.
  - If `pending`=1 at a wrap, the pending value is applied. `duty_ready` rises the next cycle, and no transfer is possible on the wrap edge itself.
- Duty semantics: duty=0 gives a constantly low output, and duty=PERIOD gives a constantly high output. Both are free of glitches.
- Comparisons use WIDTH+1-bit unsigned arithmetic, so the counter does not wrap mid-compare.

## Timing
- Values after reset:

  | Signal | Reset value |
  |---|---|
  | `phase` | 0 |
  | `duty_active` | 0 |
  | `duty_shadow` | 0 |
  | `pending` | 0 |
  | `pwm_out` | 0 |
  | `duty_ready` | 1 |
  | `period_start` | 0 |

- `pwm_out` changes only on an edge where `tick`=1, one clock after `tick` is sampled. It never changes on a non-tick edge.
- Latency from a duty transfer to effect: at most one full period plus one tick. Exactly, the effect appears at the first wrap edge after the transfer edge.
- Back-to-back ticks (`tick` high every cycle) are legal. The output then runs at the full clock rate.
- Reset mid-period or mid-handshake:
  - A pending duty is discarded.
  - `rst` has priority over `tick` and over the handshake on the same edge.
- `tick` pulses wider than one cycle count once per cycle high. Edge detection is the upstream block's responsibility.

## Configuration
- `TICK_PWM_PERIOD_PULSE_EN` defined:
  - The `period_start` output port exists.
  - It is registered high for exactly one cycle, on the cycle after every wrap edge.
- `TICK_PWM_PERIOD_PULSE_EN` undefined: the port and its register are absent, and all other behaviour is identical.

## Test plan
1. **Reset values.** Hold `rst` for 3 cycles with `tick` and `duty_valid` toggling → `pwm_out`=0 and `duty_ready`=1 throughout; `phase` is 0 on release.
2. **Duty applied at wrap.** PERIOD=4, `tick` every cycle, transfer duty=2 at cycle 1 → `duty_ready` drops the next cycle. After the first wrap, `pwm_out` repeats 1,1,0,0. `duty_ready` returns to 1 the cycle after the wrap.
3. **Extremes and saturation.** PERIOD=4 with duty=0 → `pwm_out` constant 0. With duty=4 → constant 1. With duty=200 → constant 1 (saturated).
4. **Transfer on the wrap edge.** PERIOD=4, active duty=1, transfer duty=3 on the wrap edge with `pending`=0 → the next period still runs 1,0,0,0. The period after that runs 1,1,1,0.
5. **Sparse ticks.** `tick` every 3 cycles (from `signal_generator` DELAY=3), PERIOD=4, duty=2 → `pwm_out` is high for 6 cycles and low for 6 cycles. Transitions occur exactly one clock after a tick.
6. **Reset mid-period, with the macro enabled.** Reset while `pending`=1 at phase 2 → the pending duty is lost and output stays 0. With `TICK_PWM_PERIOD_PULSE_EN` defined, `period_start` pulses once per 4 ticks and is never two cycles wide.
